// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU byte sequencer.
package lsu_pkg;

  localparam int unsigned CNT_W = 2;
  localparam int unsigned NB_W  = 3;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // Illegal size maps to 0 bytes; callers flag it separately.
  function automatic logic [NB_W-1:0] size_to_nbytes(input mem_size_e sz);
    case (sz)
      SZ_BYTE: return NB_W'(1);
      SZ_HALF: return NB_W'(2);
      SZ_WORD: return NB_W'(4);
      default: return NB_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Zero/sign extension of the assembled little-endian load bytes.
module lsu_load_format
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] asm_i,
  input  mem_size_e       size_i,
  input  logic            sign_ext_i,
  output logic [XLEN-1:0] rdata_o
);

  localparam int unsigned IDX_W = $clog2(XLEN);

  int unsigned      nbits_c;
  logic [IDX_W-1:0] msb_c;
  logic             sbit_c;

  always_comb begin
    nbits_c = 8 * 32'(size_to_nbytes(size_i));
    msb_c   = '0;
    sbit_c  = 1'b0;
    rdata_o = '0;
    if (nbits_c != 0) begin
      msb_c  = IDX_W'(nbits_c - 1);
      sbit_c = sign_ext_i & asm_i[msb_c];
    end
    for (int unsigned i = 0; i < XLEN; i++) begin
      rdata_o[i] = (i < nbits_c) ? asm_i[i] : sbit_c;
    end
  end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Breaks byte/half/word load-store requests into single-byte memory
// accesses and returns the assembled little-endian load result.
module lsu_byte_sequencer
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [1:0]        req_size,
  input  logic              req_sign_ext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [7:0]        mem_read_data
);

  localparam int unsigned IDX_W = $clog2(XLEN);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   asm_q, asm_d;
  mem_size_e         size_q, size_d;
  logic [NB_W-1:0]   nbytes_q, nbytes_d;
  logic              sign_q, sign_d;
  logic              store_q, store_d;
  logic              err_q, err_d;

  mem_size_e         req_size_c;
  logic [NB_W-1:0]   req_nb_c;
  logic [ADDR_W:0]   req_end_c;
  logic              req_err_c;
  logic              last_c;
  logic [IDX_W-1:0]  byte_idx_c;
  logic [XLEN-1:0]   fmt_rdata_c;

  // Request decode: an access may end exactly at the top of memory but not wrap.
  assign req_size_c = mem_size_e'(req_size);
  assign req_nb_c   = size_to_nbytes(req_size_c);
  assign req_end_c  = (ADDR_W+1)'(req_addr) + (ADDR_W+1)'(req_nb_c);
  assign req_err_c  = (req_size_c == SZ_ILLEGAL) || (req_end_c > {1'b1, {ADDR_W{1'b0}}});
  assign last_c     = (NB_W'(cnt_q) == (nbytes_q - NB_W'(1)));
  assign byte_idx_c = IDX_W'({cnt_q, 3'b000});

  lsu_load_format #(.XLEN(XLEN)) u_fmt (
    .asm_i      (asm_q),
    .size_i     (size_q),
    .sign_ext_i (sign_q),
    .rdata_o    (fmt_rdata_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      asm_q    <= '0;
      size_q   <= SZ_BYTE;
      nbytes_q <= '0;
      sign_q   <= 1'b0;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      asm_q    <= asm_d;
      size_q   <= size_d;
      nbytes_q <= nbytes_d;
      sign_q   <= sign_d;
      store_q  <= store_d;
      err_q    <= err_d;
    end
  end

  // Next-state, request latch, counter and load-byte assembly.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    asm_d    = asm_q;
    size_d   = size_q;
    nbytes_d = nbytes_q;
    sign_d   = sign_q;
    store_d  = store_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          size_d   = req_size_c;
          nbytes_d = req_nb_c;
          sign_d   = req_sign_ext;
          store_d  = req_is_store;
          err_d    = req_err_c;
          cnt_d    = '0;
          asm_d    = '0;
          state_d  = req_err_c ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!store_q) asm_d[byte_idx_c +: 8] = mem_read_data;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_c) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; memory strobes live only in ACCESS.
  always_comb begin
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_err        = 1'b0;
    rsp_rdata      = '0;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_write_en   = 1'b0;
    mem_read_en    = 1'b0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      ACCESS: begin
        mem_addr = addr_q + ADDR_W'(cnt_q);
        if (store_q) begin
          mem_write_en   = 1'b1;
          mem_write_data = wdata_q[byte_idx_c +: 8];
        end else begin
          mem_read_en = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (err_q || store_q) ? '0 : fmt_rdata_c;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Scoreboard bench for lsu_byte_sequencer with a byte-array memory model.
module tb_lsu_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_store, req_sign_ext;
  logic [1:0]  req_size;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  mem_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read_en;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        store;
    logic [7:0]  base;
    logic [31:0] wdata;
    int          nb;
    int          rise_cyc;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  int          strobes = 0;
  logic        prev_v = 1'b0;
  logic [31:0] held_d;
  logic        held_e;
  exp_t        mon_e;
  exp_t        rs;
  exp_t        q[$];
  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];

  always #5 clk = ~clk;

  lsu_byte_sequencer #(.ADDR_W(8), .XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_store   (req_is_store),
    .req_size       (req_size),
    .req_sign_ext   (req_sign_ext),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_en    (mem_read_en),
    .mem_read_data  (mem_read_data)
  );

  // Data memory: combinational read, write on the clock edge.
  assign mem_read_data = mem[mem_addr];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    forever begin
      @(posedge clk);
      if (mem_write_en) mem[mem_addr] <= mem_write_data;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ($urandom_range(0, 3) != 0);
      default: rsp_ready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: per-byte bus checks and response comparison at handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      strobes = 0;
      prev_v  = 1'b0;
    end else begin
      if (mem_write_en || mem_read_en) begin
        if (q.size() == 0) chk("stray_strobe", 32'd1, 32'd0);
        else begin
          mon_e = q[0];
          chk("one_strobe", 32'(mem_write_en & mem_read_en), 32'd0);
          chk("mem_addr", 32'(mem_addr), 32'(8'(mon_e.base + 8'(strobes))));
          if (mon_e.store) begin
            chk("write_en", 32'(mem_write_en), 32'd1);
            if (strobes < 4) chk("write_data", 32'(mem_write_data), 32'(mon_e.wdata[8*strobes +: 8]));
          end else begin
            chk("read_en", 32'(mem_read_en), 32'd1);
          end
        end
        strobes++;
      end else begin
        chk("mem_idle", {16'h0, mem_addr, mem_write_data}, 32'd0);
      end
      if (rsp_valid) begin
        if (q.size() == 0) chk("stray_rsp", 32'd1, 32'd0);
        else begin
          mon_e = q[0];
          if (!prev_v) begin
            chk("rsp_latency", 32'(cyc), 32'(mon_e.rise_cyc));
            held_d = rsp_rdata;
            held_e = rsp_err;
          end else begin
            chk("rdata_stable", rsp_rdata, held_d);
            chk("err_stable", 32'(rsp_err), 32'(held_e));
          end
          chk("req_ready_busy", 32'(req_ready), 32'd0);
          if (rsp_ready) begin
            chk("rsp_rdata", rsp_rdata, mon_e.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            chk("access_count", 32'(strobes), 32'(mon_e.err ? 0 : mon_e.nb));
            void'(q.pop_front());
            strobes = 0;
          end
        end
      end
      prev_v = rsp_valid;
    end
  end

  // Issue one request; the expected response is derived from ref_mem at accept.
  task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [7:0] a, input logic [31:0] wd);
    exp_t        ex;
    int          nb;
    logic [63:0] v;
    bit          done;
    done     = 1'b0;
    nb       = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ex.store = st;
    ex.base  = a;
    ex.wdata = wd;
    ex.nb    = nb;
    ex.err   = (sz == 2'd3) || (int'(a) + nb > 256);
    ex.rdata = '0;
    req_is_store = st;
    req_size     = sz;
    req_sign_ext = sg;
    req_addr     = a;
    req_wdata    = wd;
    req_valid    = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (req_ready && rst_n) begin
        ex.rise_cyc = cyc + (ex.err ? 1 : nb + 1);
        if (!ex.err) begin
          if (st) begin
            for (int k = 0; k < nb; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
          end else begin
            v = '0;
            for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[int'(a) + k];
            if (sg && v[8*nb-1]) for (int b = 8*nb; b < 64; b++) v[b] = 1'b1;
            ex.rdata = v[31:0];
          end
        end
        q.push_back(ex);
        done = 1'b1;
      end
    end
    if (!done) chk("req_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 500 && q.size() != 0; t++) @(posedge clk);
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0; req_sign_ext = 1'b0;
    req_addr = '0; req_wdata = '0;
    #1;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem", {14'h0, mem_write_en, mem_read_en, mem_addr, mem_write_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases.
    issue(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 8'h30, 32'h00000080);
    issue(1'b0, 2'd0, 1'b1, 8'h30, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 8'h30, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 8'h21, 32'h34);
    issue(1'b1, 2'd0, 1'b0, 8'h22, 32'h92);
    issue(1'b0, 2'd1, 1'b1, 8'h21, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 8'hFE, 32'h0);
    issue(1'b0, 2'd3, 1'b0, 8'h00, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 8'hFC, 32'h01020304);
    issue(1'b0, 2'd2, 1'b1, 8'hFC, 32'h0);
    wait_drain();
    chk("word_readback", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);

    // Back-pressure: hold rsp_ready low for five cycles after rsp_valid.
    rdy_mode = 2;
    issue(1'b0, 2'd2, 1'b1, 8'h10, 32'h0);
    for (int t = 0; t < 50 && !rsp_valid; t++) @(negedge clk);
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    rdy_mode = 0;
    #1;
    issue(1'b0, 2'd1, 1'b0, 8'h12, 32'h0);

    // Randomized traffic with random response back-pressure.
    rdy_mode = 1;
    for (int n = 0; n < 300; n++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(248, 255)) : 8'($urandom_range(0, 255));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rdy_mode = 0;
    wait_drain();

    // Reset during the second byte of a word store.
    rs.rdata = '0; rs.err = 1'b0; rs.store = 1'b1; rs.base = 8'h40;
    rs.wdata = 32'hA1B2C3D4; rs.nb = 4; rs.rise_cyc = 0;
    req_is_store = 1'b1; req_size = 2'd2; req_sign_ext = 1'b0;
    req_addr = 8'h40; req_wdata = 32'hA1B2C3D4; req_valid = 1'b1;
    @(negedge clk);
    chk("rst_test_ready", 32'(req_ready), 32'd1);
    q.push_back(rs);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    ref_mem[8'h40] = 8'hD4;
    #1;
    chk("rst_we_drop", 32'(mem_write_en), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      chk("post_rst_ready", 32'(req_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    issue(1'b0, 2'd2, 1'b0, 8'h40, 32'h0);
    wait_drain();

    for (int i = 0; i < 256; i++) chk($sformatf("mem_final_%02h", i), 32'(mem[i]), 32'(ref_mem[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
